servo_ramp_ctrl: RTL and testbench
==================================

# servo_ramp_ctrl

Slew-rate-limited angle sequencer that drives the 9-bit `angle` input of the servo PWM generator. It accepts target-angle commands over a valid/ready handshake and steps the output angle toward the target once per 20 ms PWM frame. It then dwells for a fixed number of frames and pulses `sig_done`. It runs its own frame counter, aligned to the PWM period, so the output angle never changes more than once per frame.

## Interface
Parameters:
- `PERIOD`, 2_000_000 — clocks per PWM frame (20 ms at 100 MHz).
- `ANGLE_MAX`, 270 — upper clamp for angles, in degrees.
- `ANGLE_INIT`, 135 — angle value at reset (mid position).
- `HOLD_FRAMES`, 4 — frames to dwell at target before `sig_done`; minimum 1.

Ports:
- `sclk` in 1 — system clock (100 MHz); the only clock.
- `rst` in 1 — synchronous, active-high reset.
- `cmd_valid` in 1 — command present.
- `cmd_ready` out 1 — block can accept a command.
- `cmd_angle` in 9 — target angle in degrees, unsigned.
- `cmd_step` in 4 — degrees per frame, unsigned.
- `abort` in 1 — cancel the current move.
- `angle` out 9 — current commanded angle, to the PWM block.
- `busy` out 1 — high in RAMP or HOLD.
- `frame_tick` out 1 — single-cycle pulse marking the last clock of each frame.
- `sig_done` out 1 — single-cycle pulse when a move completes.

## Operation
- **Frame counter** `cnt`:
  - Counts 0..PERIOD-1 and wraps to 0.
  - `frame_tick` = (`cnt` == PERIOD-1), combinational from a registered `cnt`.
  - Free-running; not affected by commands or `abort`.
- **FSM states:** IDLE, RAMP, HOLD.
- **IDLE:**
  - `cmd_ready` = 1; `busy` = 0.
  - On `cmd_valid & cmd_ready`:
    - target <= min(`cmd_angle`, ANGLE_MAX).
    - step <= (`cmd_step` == 0) ? 1 : `cmd_step`.
    - Go to RAMP.
  - `cmd_angle`/`cmd_step` are ignored when no handshake occurs.
- **RAMP:**
  - Acts only on cycles where `frame_tick` = 1; all other cycles hold.
  - On each tick:
    - If |target − `angle`| <= step: `angle` <= target, hold_cnt <= 0, go to HOLD.
    - Else if target > `angle`: `angle` <= `angle` + step.
    - Else: `angle` <= `angle` − step.
  - A target equal to the current angle is absorbed on the first tick.
- **HOLD:**
  - On each `frame_tick`: hold_cnt <= hold_cnt + 1.
  - On the tick where hold_cnt == HOLD_FRAMES-1: `sig_done` <= 1 for one cycle, go to IDLE.
- **abort:**
  - In RAMP or HOLD: go to IDLE on the next edge; `angle` frozen at its current value; no `sig_done`.
  - Ignored in IDLE.
  - If `abort` and `frame_tick` occur in the same cycle, `abort` wins and `angle` is not updated.
- **Arithmetic:**
  - Difference is computed as an unsigned 9-bit compare-then-subtract; no wrap-around.
  - `angle` always stays within [0, ANGLE_MAX].
  - `cnt` is sized ceil(log2(PERIOD)) bits.
- **Reset** (`rst` = 1 at a clock edge):
  - `cnt` = 0, state = IDLE, `angle` = ANGLE_INIT.
  - `sig_done` = 0, `busy` = 0, `frame_tick` = 0.
  - `cmd_ready` is forced to 0 while `rst` is high.
  - Reset mid-move discards target, step and hold_cnt.

## Timing
- **Command accept:** the handshake at edge N puts the FSM in RAMP at N+1; `busy` and `cmd_ready`=0 are visible in cycle N+1.
- **First update:**
  - The first `angle` change follows the first `frame_tick` observed while in RAMP.
  - The update is registered on the tick cycle's edge.
  - If the accept cycle is itself a tick cycle, that tick is not used.
- **Output stability:**
  - `angle` changes only on the edge ending a frame, so it is stable for a full frame.
  - The PWM block samples it at its own period rising edge.
- **Move duration:** ceil(|target − start| / step) ticks in RAMP, then HOLD_FRAMES ticks in HOLD.
- **Completion:** `sig_done` is high in the cycle after the final HOLD tick, concurrent with IDLE and `cmd_ready` = 1.
- **Back-to-back commands:** a new command can be accepted in the same cycle `sig_done` is high.
- **Throughput:** one command in flight; no queuing.

## Test plan
- **Reset:** assert `rst` 3 cycles, then release.
  - -> `angle`=135, `cmd_ready`=1, `busy`=0, `sig_done`=0.
  - -> `frame_tick` every PERIOD cycles; use PERIOD=10 in the bench.
- **Ramp up:** cmd 135→150, step 4.
  - -> `angle` 139, 143, 147, 150 on successive ticks.
  - -> 4 HOLD ticks, then a single `sig_done` pulse.
- **Ramp down with zero step:** cmd 135→132, step 0.
  - -> `angle` 134, 133, 132 (step treated as 1), then `sig_done`.
- **Clamp:** `cmd_angle`=300, step 15 from 135.
  - -> 9 ticks to 270; `angle` never exceeds 270.
  - -> Same-angle command (270) -> no change, HOLD, `sig_done` after 4 ticks.
- **Abort:** `abort` mid-RAMP, and again coincident with a tick.
  - -> IDLE next cycle; `angle` frozen (not updated on the coincident tick); no `sig_done`; `cmd_ready`=1.
- **Handshake and reset edge cases:**
  - `cmd_valid` held during RAMP -> not accepted until IDLE.
  - `rst` asserted in HOLD -> `angle`=135, IDLE, no `sig_done`.

Source files
------------

// File: rtl/servo_ramp_ctrl.sv
// servo_ramp_ctrl: slew-limited servo angle sequencer; takes cmd_angle/cmd_step over cmd_valid/cmd_ready, abort cancels, drives angle/busy/frame_tick/sig_done
module servo_ramp_ctrl #(
  parameter int PERIOD = 2_000_000,
  parameter int ANGLE_MAX = 270,
  parameter int ANGLE_INIT = 135,
  parameter int HOLD_FRAMES = 4
) (
  input  logic       sclk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [8:0] cmd_angle,
  input  logic [3:0] cmd_step,
  input  logic       abort,
  output logic [8:0] angle,
  output logic       busy,
  output logic       frame_tick,
  output logic       sig_done
);
  localparam int CW = PERIOD > 1 ? $clog2(PERIOD) : 1;
  localparam int HW = HOLD_FRAMES > 1 ? $clog2(HOLD_FRAMES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(PERIOD - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_FRAMES - 1);
  localparam logic [8:0] AMAX = 9'(ANGLE_MAX);
  localparam logic [8:0] AINIT = 9'(ANGLE_INIT);
  typedef enum logic [1:0] {IDLE, RAMP, HOLD} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [8:0] target;
  logic [8:0] diff;
  logic [8:0] step9;
  logic [3:0] step;
  logic [HW-1:0] hold_cnt;
  assign frame_tick = cnt == CNT_LAST;
  assign cmd_ready = state == IDLE && !rst;
  assign busy = state != IDLE;
  assign step9 = {5'd0, step};
  assign diff = target >= angle ? target - angle : angle - target;
  always_ff @(posedge sclk)
    if (rst)
      cnt <= '0;
    else
      cnt <= frame_tick ? '0 : cnt + 1'b1;
  always_ff @(posedge sclk)
    if (rst) begin
      state <= IDLE;
      angle <= AINIT;
      target <= AINIT;
      step <= 4'd1;
      hold_cnt <= '0;
      sig_done <= 1'b0;
    end else begin
      sig_done <= 1'b0;
      case (state)
        IDLE:
          if (cmd_valid) begin
            target <= cmd_angle > AMAX ? AMAX : cmd_angle;
            step <= cmd_step == 4'd0 ? 4'd1 : cmd_step;
            state <= RAMP;
          end
        RAMP:
          if (abort)
            state <= IDLE;
          else if (frame_tick) begin
            if (diff <= step9) begin
              angle <= target;
              hold_cnt <= '0;
              state <= HOLD;
            end else
              angle <= target > angle ? angle + step9 : angle - step9;
          end
        HOLD:
          if (abort)
            state <= IDLE;
          else if (frame_tick) begin
            if (hold_cnt == HOLD_LAST) begin
              sig_done <= 1'b1;
              state <= IDLE;
            end else
              hold_cnt <= hold_cnt + 1'b1;
          end
        default:
          state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_servo_ramp_ctrl.sv
// tb_servo_ramp_ctrl: table-driven, hand-written and randomized checks of servo_ramp_ctrl against a move-level model
module tb_servo_ramp_ctrl;
  localparam int P = 10;
  localparam int AMAX = 270;
  localparam int AINIT = 135;
  localparam int HF = 4;
  typedef struct {
    int a;
    int s;
    int fin;
    int ramp;
  } vec_t;
  logic sclk = 1'b0;
  logic rst = 1'b1;
  logic cmd_valid = 1'b0;
  logic abort = 1'b0;
  logic [8:0] cmd_angle = '0;
  logic [3:0] cmd_step = '0;
  logic cmd_ready, busy, frame_tick, sig_done;
  logic [8:0] angle;
  int n_cmp = 0;
  int n_bad = 0;
  int m_cnt = 0, m_angle = AINIT, m_start = AINIT, m_tgt = AINIT, m_step = 1, m_n = 1, m_k = 0;
  bit m_busy = 0, m_done = 0;
  logic [8:0] seen[$];
  int ticks_busy, dones;
  int up_exp[4] = '{139, 143, 147, 150};
  vec_t tbl[6];
  always #5 sclk = ~sclk;
  servo_ramp_ctrl #(.PERIOD(P), .ANGLE_MAX(AMAX), .ANGLE_INIT(AINIT), .HOLD_FRAMES(HF)) dut (
    .sclk(sclk),
    .rst(rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_angle(cmd_angle),
    .cmd_step(cmd_step),
    .abort(abort),
    .angle(angle),
    .busy(busy),
    .frame_tick(frame_tick),
    .sig_done(sig_done)
  );
  task automatic chk(input string nm, input int act, input int want);
    n_cmp++;
    if (act != want) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, want, $time);
    end
  endtask
  function automatic int ramp_angle(input int k);
    int up, dn;
    up = m_start + k * m_step;
    dn = m_start - k * m_step;
    if (m_tgt >= m_start) return up < m_tgt ? up : m_tgt;
    return dn > m_tgt ? dn : m_tgt;
  endfunction
  task automatic model_next();
    bit tick;
    int d;
    tick = m_cnt == P - 1;
    m_done = 0;
    if (rst) begin
      m_cnt = 0;
      m_busy = 0;
      m_angle = AINIT;
    end else begin
      m_cnt = (m_cnt + 1) % P;
      if (!m_busy) begin
        if (cmd_valid) begin
          m_start = m_angle;
          m_tgt = cmd_angle > AMAX ? AMAX : int'(cmd_angle);
          m_step = cmd_step == 0 ? 1 : int'(cmd_step);
          d = m_tgt > m_start ? m_tgt - m_start : m_start - m_tgt;
          m_n = d == 0 ? 1 : (d + m_step - 1) / m_step;
          m_k = 0;
          m_busy = 1;
        end
      end else if (abort)
        m_busy = 0;
      else if (tick) begin
        m_k++;
        if (m_k <= m_n) m_angle = ramp_angle(m_k);
        if (m_k == m_n + HF) begin
          m_busy = 0;
          m_done = 1;
        end
      end
    end
  endtask
  task automatic cyc();
    model_next();
    @(negedge sclk);
    chk("angle", int'(angle), m_angle);
    chk("busy", int'(busy), int'(m_busy));
    chk("cmd_ready", int'(cmd_ready), int'(!m_busy && !rst));
    chk("frame_tick", int'(frame_tick), int'(m_cnt == P - 1));
    chk("sig_done", int'(sig_done), int'(m_done));
  endtask
  task automatic issue(input int a, input int s);
    int w = 0;
    while (!cmd_ready && w < 5000) begin
      cyc();
      w++;
    end
    chk("issue_ready", int'(cmd_ready), 1);
    cmd_angle = 9'(a);
    cmd_step = 4'(s);
    cmd_valid = 1'b1;
    cyc();
    cmd_valid = 1'b0;
  endtask
  task automatic run_move(input int a, input int s);
    int w = 0;
    logic [8:0] prev;
    seen.delete();
    ticks_busy = 0;
    dones = 0;
    issue(a, s);
    while (!sig_done && w < 5000) begin
      if (busy && frame_tick) ticks_busy++;
      prev = angle;
      cyc();
      if (angle != prev) seen.push_back(angle);
      if (sig_done) dones++;
      w++;
    end
    chk("done_seen", int'(sig_done), 1);
    for (int i = 0; i < 2 * P; i++) begin
      cyc();
      if (sig_done) dones++;
    end
    chk("done_count", dones, 1);
  endtask
  task automatic wait_ticks(input int n);
    int t = 0, w = 0;
    while (t < n && w < 2000) begin
      if (busy && frame_tick) t++;
      cyc();
      w++;
    end
    chk("tick_wait", t, n);
  endtask
  task automatic tick_period();
    int w = 0, gap;
    while (!frame_tick && w < 3 * P) begin
      cyc();
      w++;
    end
    cyc();
    gap = 1;
    while (!frame_tick && gap < 3 * P) begin
      cyc();
      gap++;
    end
    chk("tick_period", gap, P);
  endtask
  task automatic no_done(input string nm, input int n, input int frozen);
    int d = 0;
    for (int i = 0; i < n; i++) begin
      cyc();
      if (sig_done) d++;
      if (frozen >= 0) chk({nm, "_frozen"}, int'(angle), frozen);
    end
    chk({nm, "_no_done"}, d, 0);
  endtask
  task automatic abort_mid();
    int w = 0, a0;
    issue(200, 1);
    wait_ticks(2);
    while (frame_tick && w < 3 * P) begin
      cyc();
      w++;
    end
    a0 = angle;
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_ready", int'(cmd_ready), 1);
    chk("abort_angle", int'(angle), a0);
    no_done("abort", 3 * P, a0);
  endtask
  task automatic abort_on_tick();
    int w = 0, a0;
    issue(0, 1);
    wait_ticks(1);
    while (!frame_tick && w < 3 * P) begin
      cyc();
      w++;
    end
    chk("abort_tick_aligned", int'(frame_tick), 1);
    a0 = angle;
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk("abort_tick_angle", int'(angle), a0);
    chk("abort_tick_busy", int'(busy), 0);
    no_done("abort_tick", 3 * P, a0);
  endtask
  task automatic held_valid();
    int w = 0;
    while (!cmd_ready && w < 5000) begin
      cyc();
      w++;
    end
    cmd_angle = 9'd100;
    cmd_step = 4'd15;
    cmd_valid = 1'b1;
    cyc();
    cmd_angle = 9'd60;
    chk("held_ready", int'(cmd_ready), 0);
    w = 0;
    while (!sig_done && w < 2000) begin
      cyc();
      w++;
    end
    chk("held_done", int'(sig_done), 1);
    chk("held_final", int'(angle), 100);
    cyc();
    cmd_valid = 1'b0;
    chk("b2b_busy", int'(busy), 1);
    w = 0;
    while (!sig_done && w < 2000) begin
      cyc();
      w++;
    end
    chk("b2b_final", int'(angle), 60);
  endtask
  task automatic reset_in_hold();
    int w = 0;
    issue(120, 15);
    while (!(busy && angle == 9'd120) && w < 2000) begin
      cyc();
      w++;
    end
    chk("hold_reached", int'(angle), 120);
    cyc();
    rst = 1'b1;
    cyc();
    chk("rst_hold_angle", int'(angle), AINIT);
    chk("rst_hold_busy", int'(busy), 0);
    chk("rst_hold_ready", int'(cmd_ready), 0);
    rst = 1'b0;
    no_done("rst_hold", 6 * P, AINIT);
  endtask
  initial begin
    int mx;
    tbl[0] = '{132, 0, 132, 3};
    tbl[1] = '{135, 3, 135, 1};
    tbl[2] = '{300, 15, 270, 9};
    tbl[3] = '{270, 5, 270, 1};
    tbl[4] = '{0, 15, 0, 18};
    tbl[5] = '{9, 2, 9, 5};
    rst = 1'b1;
    repeat (3) cyc();
    chk("rst_angle", int'(angle), AINIT);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(sig_done), 0);
    chk("rst_tick", int'(frame_tick), 0);
    chk("rst_ready_low", int'(cmd_ready), 0);
    rst = 1'b0;
    cyc();
    chk("ready_after_rst", int'(cmd_ready), 1);
    tick_period();
    run_move(150, 4);
    chk("up_len", seen.size(), 4);
    for (int i = 0; i < 4 && i < seen.size(); i++) chk("up_angle", int'(seen[i]), up_exp[i]);
    chk("up_ticks", ticks_busy, 4 + HF);
    issue(135, 15);
    wait_ticks(1 + HF);
    cyc();
    for (int i = 0; i < 6; i++) begin
      run_move(tbl[i].a, tbl[i].s);
      chk("tbl_final", int'(angle), tbl[i].fin);
      chk("tbl_ticks", ticks_busy, tbl[i].ramp + HF);
      mx = 0;
      foreach (seen[j]) if (int'(seen[j]) > mx) mx = seen[j];
      chk("tbl_max_ok", int'(mx <= AMAX), 1);
    end
    abort_mid();
    abort_on_tick();
    held_valid();
    reset_in_hold();
    for (int i = 0; i < 4000; i++) begin
      rst = $urandom_range(0, 399) == 0;
      cmd_valid = $urandom_range(0, 3) == 0;
      cmd_angle = 9'($urandom_range(0, 511));
      cmd_step = 4'($urandom_range(0, 15));
      abort = $urandom_range(0, 59) == 0;
      cyc();
    end
    rst = 1'b0;
    cmd_valid = 1'b0;
    abort = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
